// File: rtl/tod_counter.sv
// Time-of-day counter: prescaled seconds/minutes/hours with range-checked load, carry pulses, optional alarm (TOD_ALARM_EN).
// Latency: one cycle from prescaler terminal count or load strobe to updated fields and pulses.
// Backpressure: none; en freezes the prescaler, load takes priority over a coincident tick.
module tod_counter #(
  parameter int CLK_DIV       = 50_000_000,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_ack,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       load_err,
  output logic       alarm_ring
);

  localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   DIV_LAST  = PW'(CLK_DIV - 1);
  localparam logic [4:0]      HOUR_LAST = 5'(HOURS_PER_DAY - 1);
  // Six bits so that a 32-hour day still has a representable limit.
  localparam logic [5:0]      HOUR_LIM  = 6'(HOURS_PER_DAY);

  logic [PW-1:0] presc;
  logic          tick;
  logic          load_ok;
  logic          load_take;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hr_wrap;
  logic [5:0]    nxt_ss;
  logic [5:0]    nxt_mm;
  logic [4:0]    nxt_hh;

  assign tick      = en && (presc == DIV_LAST);
  assign load_ok   = (load_ss < 6'd60) && (load_mm < 6'd60) && ({1'b0, load_hh} < HOUR_LIM);
  assign load_take = load && load_ok;

  assign sec_wrap = (seconds == 6'd59);
  assign min_wrap = sec_wrap && (minutes == 6'd59);
  assign hr_wrap  = min_wrap && (hours == HOUR_LAST);

  always_comb begin
    nxt_ss = sec_wrap ? 6'd0 : seconds + 6'd1;
    nxt_mm = minutes;
    nxt_hh = hours;
    if (sec_wrap) begin
      nxt_mm = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end
    if (min_wrap) begin
      nxt_hh = hr_wrap ? 5'd0 : hours + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      hours     <= 5'd0;
      minutes   <= 6'd0;
      seconds   <= 6'd0;
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      day_tick  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      day_tick  <= 1'b0;
      load_err  <= 1'b0;
      if (load_take) begin
        hours   <= load_hh;
        minutes <= load_mm;
        seconds <= load_ss;
        presc   <= '0;
      end else begin
        // A rejected load leaves normal counting untouched.
        load_err <= load;
        if (en) begin
          presc <= tick ? '0 : presc + PW'(1);
        end
        if (tick) begin
          seconds   <= nxt_ss;
          minutes   <= nxt_mm;
          hours     <= nxt_hh;
          sec_tick  <= 1'b1;
          min_tick  <= sec_wrap;
          hour_tick <= min_wrap;
          day_tick  <= hr_wrap;
        end
      end
    end
  end

`ifdef TOD_ALARM_EN
  logic [4:0] al_hh;
  logic [5:0] al_mm;
  logic       armed;
  logic       fire;

  // Only a counted rollover into second 0 can fire; loads never do.
  assign fire = armed && tick && !load_take && sec_wrap &&
                (nxt_mm == al_mm) && (nxt_hh == al_hh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_hh      <= 5'd0;
      al_mm      <= 6'd0;
      armed      <= 1'b0;
      alarm_ring <= 1'b0;
    end else begin
      if (alarm_set) begin
        al_hh <= alarm_hh;
        al_mm <= alarm_mm;
        armed <= 1'b1;
      end
      if (fire) begin
        alarm_ring <= 1'b1;
      end else if (alarm_ack) begin
        alarm_ring <= 1'b0;
      end
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_set, alarm_hh, alarm_mm, alarm_ack};
  assign alarm_ring   = 1'b0;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter: load table, hand-written corner sequences and a random run against a seconds-of-day model.
module tb_tod_counter;

  localparam int CLK_DIV = 4;
  localparam int HPD     = 24;
  localparam int DAY     = HPD * 3600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, load, alarm_set, alarm_ack;
  logic [4:0] load_hh, alarm_hh;
  logic [5:0] load_mm, load_ss, alarm_mm;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       sec_tick, min_tick, hour_tick, day_tick, load_err, alarm_ring;

  tod_counter #(.CLK_DIV(CLK_DIV), .HOURS_PER_DAY(HPD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .alarm_set(alarm_set), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_ack(alarm_ack),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick), .day_tick(day_tick),
    .load_err(load_err), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as seconds of the day, prescaler as enabled-cycle count.
  int m_t, m_cnt, m_al_h, m_al_m;
  bit m_sec, m_min, m_hr, m_day, m_err, m_armed, m_ring;

  typedef struct {
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    bit         err;
    int         exp_t;
  } load_vec_t;

  load_vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_cnt = 0; m_al_h = 0; m_al_m = 0;
    m_sec = 0; m_min = 0; m_hr = 0; m_day = 0; m_err = 0; m_armed = 0; m_ring = 0;
  endtask

  function automatic int now_t();
    return int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds);
  endfunction

  // One clock: advance the model from the inputs in force, then compare after the edge.
  task automatic cycle();
    bit valid, tk, fire;
    valid = load && (load_ss < 60) && (load_mm < 60) && (int'(load_hh) < HPD);
    m_sec = 0; m_min = 0; m_hr = 0; m_day = 0; m_err = 0;
    tk = 0; fire = 0;
    if (valid) begin
      m_t   = int'(load_hh) * 3600 + int'(load_mm) * 60 + int'(load_ss);
      m_cnt = 0;
    end else begin
      m_err = load;
      if (en) begin
        m_cnt++;
        if (m_cnt == CLK_DIV) begin
          m_cnt = 0;
          tk    = 1;
        end
      end
      if (tk) begin
        m_t   = (m_t + 1) % DAY;
        m_sec = 1;
        m_min = (m_t % 60) == 0;
        m_hr  = (m_t % 3600) == 0;
        m_day = (m_t == 0);
      end
    end
`ifdef TOD_ALARM_EN
    fire = m_armed && tk && (m_t % 60 == 0) && (m_t / 3600 == m_al_h) && ((m_t / 60) % 60 == m_al_m);
    if (fire) m_ring = 1;
    else if (alarm_ack) m_ring = 0;
    if (alarm_set) begin
      m_al_h  = int'(alarm_hh);
      m_al_m  = int'(alarm_mm);
      m_armed = 1;
    end
`endif
    @(posedge clk);
    #1;
    chk("time", now_t(), m_t);
    chk("flags", int'({sec_tick, min_tick, hour_tick, day_tick, load_err, alarm_ring}),
        int'({m_sec, m_min, m_hr, m_day, m_err, m_ring}));
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1; load_hh = 5'(h); load_mm = 6'(m); load_ss = 6'(s);
    cycle();
    load = 0;
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; alarm_set = 0; alarm_ack = 0;
    load_hh = 0; load_mm = 0; load_ss = 0; alarm_hh = 0; alarm_mm = 0;
    model_reset();

    vecs[0] = '{5'd12, 6'd30, 6'd15, 1'b0, 45015};
    vecs[1] = '{5'd24, 6'd10, 6'd0,  1'b1, 45015};
    vecs[2] = '{5'd12, 6'd60, 6'd0,  1'b1, 45015};
    vecs[3] = '{5'd0,  6'd0,  6'd60, 1'b1, 45015};
    vecs[4] = '{5'd23, 6'd59, 6'd59, 1'b0, 86399};
    vecs[5] = '{5'd31, 6'd63, 6'd63, 1'b1, 86399};
    vecs[6] = '{5'd0,  6'd0,  6'd0,  1'b0, 0};
    vecs[7] = '{5'd5,  6'd59, 6'd0,  1'b0, 21540};

    #2;
    chk("reset_time", now_t(), 0);
    chk("reset_flags", int'({sec_tick, min_tick, hour_tick, day_tick, load_err, alarm_ring}), 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // First tick lands on the 4th enabled edge.
    en = 1;
    for (int i = 1; i <= CLK_DIV; i++) begin
      cycle();
      chk("first_tick_sec", int'(seconds), (i == CLK_DIV) ? 1 : 0);
      chk("first_tick_pulse", int'(sec_tick), (i == CLK_DIV) ? 1 : 0);
    end

    // Seconds 59 -> 0 carries into minutes.
    do_load(0, 0, 59);
    repeat (CLK_DIV) cycle();
    chk("min_carry_time", now_t(), 60);
    chk("min_carry_pulse", int'({sec_tick, min_tick, hour_tick}), 3'b110);

    // Full-day rollover: all four pulses coincide for one cycle.
    do_load(23, 59, 59);
    repeat (CLK_DIV) cycle();
    chk("day_wrap_time", now_t(), 0);
    chk("day_wrap_pulses", int'({sec_tick, min_tick, hour_tick, day_tick}), 4'b1111);
    cycle();
    chk("day_wrap_pulse_width", int'({sec_tick, min_tick, hour_tick, day_tick}), 0);

    // Load table with counting frozen so the expected time is exact.
    en = 0;
    foreach (vecs[i]) begin
      load = 1; load_hh = vecs[i].hh; load_mm = vecs[i].mm; load_ss = vecs[i].ss;
      cycle();
      load = 0;
      chk("tbl_err", int'(load_err), int'(vecs[i].err));
      chk("tbl_time", now_t(), vecs[i].exp_t);
      cycle();
      chk("tbl_err_clear", int'(load_err), 0);
    end

    // Load coincident with a terminal count: tick discarded, prescaler restarts.
    en = 1;
    do_load(1, 2, 3);
    repeat (CLK_DIV - 1) cycle();
    do_load(4, 5, 6);
    chk("coinc_time", now_t(), 4 * 3600 + 5 * 60 + 6);
    chk("coinc_no_tick", int'(sec_tick), 0);
    repeat (CLK_DIV - 1) cycle();
    chk("coinc_pre_tick", int'(seconds), 6);
    cycle();
    chk("coinc_next_tick", int'({seconds, sec_tick}), {6'd7, 1'b1});

    // en dropped at prescaler = 2 freezes everything for 10 cycles.
    do_load(10, 0, 0);
    repeat (2) cycle();
    en = 0;
    repeat (10) cycle();
    chk("en_hold_time", now_t(), 36000);
    en = 1;
    cycle();
    chk("en_resume_1", int'(sec_tick), 0);
    cycle();
    chk("en_resume_2", int'({seconds, sec_tick}), {6'd1, 1'b1});

    // Asynchronous reset mid-count clears at once.
    do_load(7, 7, 7);
    cycle();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_time", now_t(), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (CLK_DIV - 1) cycle();
    chk("rst_pre_tick", int'(sec_tick), 0);
    cycle();
    chk("rst_first_tick", int'({seconds, sec_tick}), {6'd1, 1'b1});

`ifdef TOD_ALARM_EN
    alarm_set = 1; alarm_hh = 0; alarm_mm = 1;
    cycle();
    alarm_set = 0;
    do_load(0, 0, 58);
    repeat (2 * CLK_DIV) cycle();
    chk("alarm_fire_time", now_t(), 60);
    chk("alarm_fire_ring", int'(alarm_ring), 1);
    repeat (3) cycle();
    alarm_set = 1; alarm_hh = 3; alarm_mm = 3;
    cycle();
    alarm_set = 0;
    chk("alarm_set_keeps_ring", int'(alarm_ring), 1);
    alarm_ack = 1;
    cycle();
    alarm_ack = 0;
    chk("alarm_ack_clears", int'(alarm_ring), 0);
    alarm_set = 1; alarm_hh = 0; alarm_mm = 1;
    cycle();
    alarm_set = 0;
    do_load(0, 1, 0);
    cycle();
    chk("alarm_load_no_fire", int'(alarm_ring), 0);
`endif

    // Random run against the model, loads biased towards field boundaries.
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 9) < 8);
      load      = ($urandom_range(0, 39) == 0);
      load_hh   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(22, 25));
      load_mm   = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(57, 61));
      load_ss   = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(55, 61));
      alarm_set = ($urandom_range(0, 49) == 0);
      alarm_hh  = load_hh;
      alarm_mm  = 6'(load_mm + 6'd1);
      alarm_ack = ($urandom_range(0, 29) == 0);
      cycle();
    end
    load = 0; alarm_set = 0; alarm_ack = 0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
